// File: rtl/ysyx_22040210_pcgen_pkg.sv
// Shared definitions for the fetch PC generator: FSM encoding, reset PC, bus widths.
// Optional dual-slot fetch groups are enabled by YSYX_22040210_PCGEN_DUALSLOT_EN.
// Pure declarations; no logic, no latency.
package ysyx_22040210_pcgen_pkg;

    // InstAdderBus width
    localparam int INST_ADDR_W = 64;
    // Packet metadata field widths
    localparam int TAKEN_W     = 2;
    localparam int TARGET_W    = INST_ADDR_W;

    localparam logic [INST_ADDR_W-1:0] PCGEN_RESET_PC = 64'h8000_0000;
    localparam logic [INST_ADDR_W-1:0] SLOT_BYTES     = 64'd4;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } pcgen_state_t;

    // Sequential successor of a fetch group: one or two 4-byte slots, wrapping.
    function automatic logic [INST_ADDR_W-1:0] seq_next_pc(
        input logic [INST_ADDR_W-1:0] pc,
        input logic                   slot1_ok
    );
        return pc + (slot1_ok ? (SLOT_BYTES << 1) : SLOT_BYTES);
    endfunction

endpackage

// File: rtl/ysyx_22040210_pcgen_nextpc.sv
// Next-PC and slot selection for one fetch group (YSYX_22040210_PCGEN_DUALSLOT_EN enables slot 1).
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, consumed by the top on the first WAIT cycle.
module ysyx_22040210_pcgen_nextpc
    import ysyx_22040210_pcgen_pkg::*;
(
    input  logic [INST_ADDR_W-1:0] pc,
    input  logic                   bpu1hit,
    input  logic                   bpu2hit,
    input  logic [INST_ADDR_W-1:0] bpu1hitaddr,
    input  logic [INST_ADDR_W-1:0] bpu2hitaddr,
    output logic [INST_ADDR_W-1:0] next_pc,
    output logic                   slot1v,
    output logic [TAKEN_W-1:0]     taken,
    output logic [TARGET_W-1:0]    target
);

    logic slot1_ok;

`ifdef YSYX_22040210_PCGEN_DUALSLOT_EN
    // Slot 1 exists only when the group starts on an 8-byte boundary.
    assign slot1_ok = ~pc[2];
`else
    assign slot1_ok = 1'b0;
`endif

    // Slot 0 prediction wins; slot 1 only counts when it exists and slot 0 falls through.
    always_comb begin
        taken   = '0;
        target  = '0;
        next_pc = seq_next_pc(pc, slot1_ok);
        slot1v  = slot1_ok && !bpu1hit;
        if (bpu1hit) begin
            taken   = 2'b01;
            target  = bpu1hitaddr;
            next_pc = bpu1hitaddr;
        end else if (slot1_ok && bpu2hit) begin
            taken   = 2'b10;
            target  = bpu2hitaddr;
            next_pc = bpu2hitaddr;
        end
    end

endmodule

// File: rtl/ysyx_22040210_pcgen.sv
// Fetch PC generator: one outstanding I-cache request, BPU redirect, back-end flush (YSYX_22040210_PCGEN_DUALSLOT_EN for two-slot groups).
// Latency: request issued in REQ; packet out on the response cycle (BPU bypassed if response is immediate).
// Backpressure: stall blocks new requests only; req_ready_i holds req_pc_o; responses are never dropped by stall.
module ysyx_22040210_pcgen
    import ysyx_22040210_pcgen_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = PCGEN_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush_i,
    input  logic [INST_ADDR_W-1:0] flush_pc_i,
    input  logic                   bpu1hit_i,
    input  logic                   bpu2hit_i,
    input  logic [INST_ADDR_W-1:0] bpu1hitaddr_i,
    input  logic [INST_ADDR_W-1:0] bpu2hitaddr_i,
    output logic [INST_ADDR_W-1:0] fetchpc_o,
    output logic                   req_valid_o,
    input  logic                   req_ready_i,
    output logic [INST_ADDR_W-1:0] req_pc_o,
    input  logic                   resp_valid_i,
    output logic                   out_valid_o,
    output logic [INST_ADDR_W-1:0] out_pc_o,
    output logic                   out_slot1v_o,
    output logic [TAKEN_W-1:0]     out_taken_o,
    output logic [TARGET_W-1:0]    out_target_o
);

    pcgen_state_t            state;
    pcgen_state_t            state_nxt;
    logic [INST_ADDR_W-1:0]  pc_q;
    logic                    first_q;
    logic [INST_ADDR_W-1:0]  meta_pc;
    logic                    meta_slot1v;
    logic [TAKEN_W-1:0]      meta_taken;
    logic [TARGET_W-1:0]     meta_target;

    logic [INST_ADDR_W-1:0]  np_pc;
    logic                    np_slot1v;
    logic [TAKEN_W-1:0]      np_taken;
    logic [TARGET_W-1:0]     np_target;
    logic                    accept;
    logic                    resp_ok;

    ysyx_22040210_pcgen_nextpc u_nextpc (
        .pc          (pc_q),
        .bpu1hit     (bpu1hit_i),
        .bpu2hit     (bpu2hit_i),
        .bpu1hitaddr (bpu1hitaddr_i),
        .bpu2hitaddr (bpu2hitaddr_i),
        .next_pc     (np_pc),
        .slot1v      (np_slot1v),
        .taken       (np_taken),
        .target      (np_target)
    );

    assign req_valid_o = (state == ST_REQ) && !stall && !rst;
    assign req_pc_o    = pc_q;
    assign fetchpc_o   = pc_q;
    assign accept      = req_valid_o && req_ready_i;
    assign resp_ok     = (state == ST_WAIT) && resp_valid_i && !flush_i && !rst;

    // Next state: flush overrides everything; a flushed WAIT drops the late response.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_REQ: begin
                if (!flush_i && accept) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush_i)           state_nxt = resp_valid_i ? ST_REQ : ST_DROP;
                else if (resp_valid_i) state_nxt = ST_REQ;
            end
            ST_DROP: begin
                if (!flush_i && resp_valid_i) state_nxt = ST_REQ;
            end
            default: state_nxt = ST_REQ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_REQ;
        else     state <= state_nxt;
    end

    // Fetch PC: redirect on flush, otherwise advance once per request on the BPU-valid cycle.
    always_ff @(posedge clk) begin
        if (rst)                            pc_q <= RESET_PC;
        else if (flush_i)                   pc_q <= flush_pc_i;
        else if (state == ST_WAIT && first_q) pc_q <= np_pc;
    end

    // Marks the first WAIT cycle, when BPU results for the fetched PC are valid.
    always_ff @(posedge clk) begin
        if (rst) first_q <= 1'b0;
        else     first_q <= (state == ST_REQ) && accept && !flush_i;
    end

    // Capture packet metadata alongside the PC advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_pc     <= '0;
            meta_slot1v <= 1'b0;
            meta_taken  <= '0;
            meta_target <= '0;
        end else if (state == ST_WAIT && first_q && !flush_i) begin
            meta_pc     <= pc_q;
            meta_slot1v <= np_slot1v;
            meta_taken  <= np_taken;
            meta_target <= np_target;
        end
    end

    // Packet output: bypass live BPU values when the response beats the metadata capture.
    always_comb begin
        out_valid_o  = 1'b0;
        out_pc_o     = '0;
        out_slot1v_o = 1'b0;
        out_taken_o  = '0;
        out_target_o = '0;
        if (resp_ok) begin
            out_valid_o = 1'b1;
            if (first_q) begin
                out_pc_o     = pc_q;
                out_slot1v_o = np_slot1v;
                out_taken_o  = np_taken;
                out_target_o = np_target;
            end else begin
                out_pc_o     = meta_pc;
                out_slot1v_o = meta_slot1v;
                out_taken_o  = meta_taken;
                out_target_o = meta_target;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040210_pcgen.sv
// Bench for the fetch PC generator; follows YSYX_22040210_PCGEN_DUALSLOT_EN when defined.
// Transaction-level model checked every cycle, plus directed literal expectations.
// Inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_ysyx_22040210_pcgen;

`ifdef YSYX_22040210_PCGEN_DUALSLOT_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush_i;
    logic [63:0] flush_pc_i;
    logic        bpu1hit_i;
    logic        bpu2hit_i;
    logic [63:0] bpu1hitaddr_i;
    logic [63:0] bpu2hitaddr_i;
    logic [63:0] fetchpc_o;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [63:0] req_pc_o;
    logic        resp_valid_i;
    logic        out_valid_o;
    logic [63:0] out_pc_o;
    logic        out_slot1v_o;
    logic [1:0]  out_taken_o;
    logic [63:0] out_target_o;

    ysyx_22040210_pcgen dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush_i       (flush_i),
        .flush_pc_i    (flush_pc_i),
        .bpu1hit_i     (bpu1hit_i),
        .bpu2hit_i     (bpu2hit_i),
        .bpu1hitaddr_i (bpu1hitaddr_i),
        .bpu2hitaddr_i (bpu2hitaddr_i),
        .fetchpc_o     (fetchpc_o),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready_i),
        .req_pc_o      (req_pc_o),
        .resp_valid_i  (resp_valid_i),
        .out_valid_o   (out_valid_o),
        .out_pc_o      (out_pc_o),
        .out_slot1v_o  (out_slot1v_o),
        .out_taken_o   (out_taken_o),
        .out_target_o  (out_target_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int out_pulses = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Fetch-group rule: slot 0 always, slot 1 when enabled and 8-byte aligned.
    task automatic predict(input logic [63:0] pc, input logic h1, input logic h2,
                           input logic [63:0] a1, input logic [63:0] a2,
                           output logic [63:0] nxt, output logic s1v,
                           output logic [1:0] tk, output logic [63:0] tgt);
        bit two;
        two = DUAL && (pc % 64'd8 == 64'd0);
        s1v = two && !h1;
        if (h1) begin
            nxt = a1; tk = 2'b01; tgt = a1;
        end else if (two && h2) begin
            nxt = a2; tk = 2'b10; tgt = a2;
        end else begin
            nxt = pc + (two ? 64'd8 : 64'd4); tk = 2'b00; tgt = 64'd0;
        end
    endtask

    // Model: idle (ready to request at m_pc), busy (awaiting response for m_fpc), or discarding.
    bit          m_busy  = 1'b0;
    bit          m_drop  = 1'b0;
    bit          m_first = 1'b0;
    logic [63:0] m_pc    = RST_PC;
    logic [63:0] m_fpc   = '0;
    logic        m_s1v   = 1'b0;
    logic [1:0]  m_tk    = '0;
    logic [63:0] m_tgt   = '0;

    always @(negedge clk) begin
        logic [63:0] nx;
        logic [63:0] tg;
        logic        s1;
        logic [1:0]  tk;
        bit          exp_ov;
        if (out_valid_o === 1'b1) out_pulses++;
        if (rst) begin
            chk("rst_req_valid", {63'd0, req_valid_o}, 64'd0);
            chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
            chk("rst_out_pc", out_pc_o, 64'd0);
            chk("rst_out_taken", {62'd0, out_taken_o}, 64'd0);
            chk("rst_out_target", out_target_o, 64'd0);
            m_busy = 1'b0; m_drop = 1'b0; m_first = 1'b0; m_pc = RST_PC;
        end else begin
            chk("req_valid", {63'd0, req_valid_o}, {63'd0, !m_busy && !m_drop && !stall});
            if (!m_busy && !m_drop) begin
                chk("req_pc", req_pc_o, m_pc);
                chk("fetchpc", fetchpc_o, m_pc);
            end
            exp_ov = m_busy && resp_valid_i && !flush_i;
            chk("out_valid", {63'd0, out_valid_o}, {63'd0, exp_ov});
            if (m_busy && m_first)
                predict(m_fpc, bpu1hit_i, bpu2hit_i, bpu1hitaddr_i, bpu2hitaddr_i, nx, s1, tk, tg);
            else begin
                nx = m_pc; s1 = m_s1v; tk = m_tk; tg = m_tgt;
            end
            if (exp_ov) begin
                chk("out_pc", out_pc_o, m_fpc);
                chk("out_slot1v", {63'd0, out_slot1v_o}, {63'd0, s1});
                chk("out_taken", {62'd0, out_taken_o}, {62'd0, tk});
                chk("out_target", out_target_o, tg);
            end
            // advance to the next cycle
            if (flush_i) begin
                m_pc = flush_pc_i;
                if (m_busy) begin
                    m_busy = 1'b0;
                    m_drop = !resp_valid_i;
                end
                m_first = 1'b0;
            end else if (m_drop) begin
                if (resp_valid_i) m_drop = 1'b0;
            end else if (m_busy) begin
                if (m_first) begin
                    m_pc = nx; m_s1v = s1; m_tk = tk; m_tgt = tg; m_first = 1'b0;
                end
                if (resp_valid_i) m_busy = 1'b0;
            end else if (!stall && req_ready_i) begin
                m_busy = 1'b1; m_first = 1'b1; m_fpc = m_pc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer ready until a request is taken; returns in the first WAIT cycle.
    task automatic wait_accept(output logic [63:0] pc);
        bit ok;
        ok = 1'b0;
        pc = '0;
        req_ready_i = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (req_valid_o === 1'b1) begin
                ok = 1'b1;
                pc = req_pc_o;
            end
            step();
        end
        req_ready_i = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_accept: no request within 50 cycles, got none, expected one");
        end
    endtask

    task automatic fetch(input int delay, input logic h1, input logic h2,
                         input logic [63:0] a1, input logic [63:0] a2,
                         output logic [63:0] pc, output logic s1v,
                         output logic [1:0] tk, output logic [63:0] tg);
        wait_accept(pc);
        bpu1hit_i = h1; bpu2hit_i = h2; bpu1hitaddr_i = a1; bpu2hitaddr_i = a2;
        for (int d = 0; d < delay; d++) begin
            step();
            bpu1hit_i = 1'($urandom_range(0, 1));
            bpu2hit_i = 1'($urandom_range(0, 1));
            bpu1hitaddr_i = {$urandom, $urandom};
            bpu2hitaddr_i = {$urandom, $urandom};
        end
        resp_valid_i = 1'b1;
        @(negedge clk);
        chk("fetch_out_valid", {63'd0, out_valid_o}, 64'd1);
        s1v = out_slot1v_o; tk = out_taken_o; tg = out_target_o;
        step();
        resp_valid_i = 1'b0;
        bpu1hit_i = 1'b0; bpu2hit_i = 1'b0; bpu1hitaddr_i = '0; bpu2hitaddr_i = '0;
    endtask

    task automatic flush_in_req(input logic [63:0] pc);
        stall = 1'b1; flush_i = 1'b1; flush_pc_i = pc;
        step();
        flush_i = 1'b0; stall = 1'b0;
    endtask

    initial begin
        logic [63:0] p0, p1, p2, tg, hold, pv;
        logic        s1v;
        logic [1:0]  tk;
        int          pulses0;

        rst = 1'b1; stall = 1'b0; flush_i = 1'b0; flush_pc_i = '0;
        bpu1hit_i = 1'b0; bpu2hit_i = 1'b0; bpu1hitaddr_i = '0; bpu2hitaddr_i = '0;
        req_ready_i = 1'b0; resp_valid_i = 1'b0;
        @(negedge clk);
        chk("reset_req_valid_lit", {63'd0, req_valid_o}, 64'd0);
        step();
        rst = 1'b0;

        // Straight-line fetch, no predictions
        fetch(0, 1'b0, 1'b0, 64'd0, 64'd0, p0, s1v, tk, tg);
        chk("seq_pc0", p0, 64'h8000_0000);
        chk("seq_slot1v", {63'd0, s1v}, DUAL ? 64'd1 : 64'd0);
        fetch(0, 1'b0, 1'b0, 64'd0, 64'd0, p1, s1v, tk, tg);
        fetch(0, 1'b0, 1'b0, 64'd0, 64'd0, p2, s1v, tk, tg);
`ifdef YSYX_22040210_PCGEN_DUALSLOT_EN
        chk("seq_pc1", p1, 64'h8000_0008);
        chk("seq_pc2", p2, 64'h8000_0010);
`else
        chk("seq_pc1", p1, 64'h8000_0004);
        chk("seq_pc2", p2, 64'h8000_0008);
`endif

        // Misaligned group: single slot, slot-1 hit ignored
        flush_in_req(64'h8000_0004);
        fetch(1, 1'b0, 1'b1, 64'd0, 64'h8000_5000, p0, s1v, tk, tg);
        chk("odd_pc", p0, 64'h8000_0004);
        chk("odd_slot1v", {63'd0, s1v}, 64'd0);
        chk("odd_taken", {62'd0, tk}, 64'd0);

        // Slot-0 hit beats slot-1 hit
        fetch(0, 1'b1, 1'b1, 64'h8000_1000, 64'h8000_3000, p0, s1v, tk, tg);
        chk("hit0_pc", p0, 64'h8000_0008);
        chk("hit0_taken", {62'd0, tk}, 64'd1);
        chk("hit0_slot1v", {63'd0, s1v}, 64'd0);
        chk("hit0_target", tg, 64'h8000_1000);
        fetch(2, 1'b0, 1'b0, 64'd0, 64'd0, p0, s1v, tk, tg);
        chk("hit0_next", p0, 64'h8000_1000);

        // Slot-1 hit from an aligned group
        fetch(1, 1'b0, 1'b1, 64'd0, 64'h8000_6000, p0, s1v, tk, tg);
        fetch(0, 1'b0, 1'b0, 64'd0, 64'd0, p1, s1v, tk, tg);
`ifdef YSYX_22040210_PCGEN_DUALSLOT_EN
        chk("hit1_pc", p0, 64'h8000_1008);
        chk("hit1_next", p1, 64'h8000_6000);
`else
        chk("hit1_pc", p0, 64'h8000_1004);
        chk("hit1_next", p1, 64'h8000_1008);
`endif

        // Flush in WAIT, late response two cycles later is swallowed
        wait_accept(p0);
        flush_i = 1'b1; flush_pc_i = 64'h8000_2000;
        pulses0 = out_pulses;
        step();
        flush_i = 1'b0;
        step();
        resp_valid_i = 1'b1;
        step();
        resp_valid_i = 1'b0;
        step();
        chk("drop_no_out", 64'(out_pulses), 64'(pulses0));
        fetch(0, 1'b0, 1'b0, 64'd0, 64'd0, p0, s1v, tk, tg);
        chk("drop_next", p0, 64'h8000_2000);

        // Flush coincident with response
        wait_accept(p0);
        step();
        resp_valid_i = 1'b1; flush_i = 1'b1; flush_pc_i = 64'h8000_4000;
        @(negedge clk);
        chk("flushresp_out_valid", {63'd0, out_valid_o}, 64'd0);
        step();
        resp_valid_i = 1'b0; flush_i = 1'b0;
        fetch(0, 1'b0, 1'b0, 64'd0, 64'd0, p0, s1v, tk, tg);
        chk("flushresp_next", p0, 64'h8000_4000);

        // Not-ready holds the request; stall withdraws it
        hold = DUAL ? 64'h8000_4008 : 64'h8000_4004;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, req_valid_o}, 64'd1);
            chk("hold_pc", req_pc_o, hold);
            step();
        end
        stall = 1'b1;
        @(negedge clk);
        chk("stall_req_valid", {63'd0, req_valid_o}, 64'd0);
        step();
        stall = 1'b0;

        // Stall does not drop an in-flight response
        wait_accept(p0);
        stall = 1'b1;
        step();
        resp_valid_i = 1'b1;
        @(negedge clk);
        chk("stall_resp_valid", {63'd0, out_valid_o}, 64'd1);
        chk("stall_resp_pc", out_pc_o, hold);
        step();
        resp_valid_i = 1'b0; stall = 1'b0;

        // Address wrap at the top of the space
        flush_in_req(64'hFFFF_FFFF_FFFF_FFF8);
        fetch(0, 1'b0, 1'b0, 64'd0, 64'd0, p0, s1v, tk, tg);
        fetch(0, 1'b0, 1'b0, 64'd0, 64'd0, p1, s1v, tk, tg);
        chk("wrap_pc", p0, 64'hFFFF_FFFF_FFFF_FFF8);
        pv = DUAL ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFC;
        chk("wrap_next", p1, pv);

        // Reset while a request is outstanding
        wait_accept(p0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        fetch(0, 1'b0, 1'b0, 64'd0, 64'd0, p0, s1v, tk, tg);
        chk("midrst_pc", p0, 64'h8000_0000);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
